fetch_stage: RTL and testbench

//   Instruction-fetch stage directly upstream of decode. Holds the PC, issues

---
 rtl/fetch_stage.sv | 72 +++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC holder with single-outstanding instruction-bus requests and a
// 2-entry {pc,instr} queue toward decode; redirects flush and squash in-flight fetches.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);
  logic [63:0] r_pc, r_addr;
  logic        r_busy, r_drop, r_head, r_tail;
  logic [1:0]  r_count;
  logic [63:0] r_q_pc [2];
  logic [31:0] r_q_instr [2];
  logic        w_resp, w_push, w_pop, w_free, w_start;
  logic [1:0]  w_count_next;
  logic [63:0] w_pc_next;
  assign w_resp       = r_busy && iresp_data_ok;
  assign w_push       = w_resp && !r_drop && !redirect_valid;
  assign w_pop        = out_valid && out_ready && !redirect_valid;
  assign w_count_next = redirect_valid ? 2'd0 : r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_pc_next    = redirect_valid ? redirect_pc : w_push ? r_addr + 64'd4 : r_pc;
  assign w_free       = !r_busy || iresp_data_ok;
  // Issue only when the queue is guaranteed a free slot for the returning word
  assign w_start      = w_free && (w_count_next <= 2'd1);
  assign ireq_valid   = r_busy;
  assign ireq_addr    = r_addr;
  assign out_valid    = r_count != 2'd0;
  assign out_pc       = r_q_pc[r_head];
  assign out_instr    = r_q_instr[r_head];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc         <= RESET_PC;
      r_addr       <= '0;
      r_busy       <= 1'b0;
      r_drop       <= 1'b0;
      r_count      <= '0;
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_q_pc[0]    <= '0;
      r_q_pc[1]    <= '0;
      r_q_instr[0] <= '0;
      r_q_instr[1] <= '0;
    end else begin
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      r_head  <= redirect_valid ? 1'b0 : r_head ^ w_pop;
      r_tail  <= redirect_valid ? 1'b0 : r_tail ^ w_push;
      if (w_free) r_busy <= w_start;
      if (w_start) r_addr <= w_pc_next;
      // A redirect with the bus still pending must swallow the stale response
      if (redirect_valid && r_busy && !iresp_data_ok) r_drop <= 1'b1;
      else if (w_resp) r_drop <= 1'b0;
      if (w_push) begin
        r_q_pc[r_tail]    <= r_addr;
        r_q_instr[r_tail] <= iresp_data;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n) assert (!(w_push && r_count == 2'd2));
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios against a latency-programmable instruction memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ireq_valid, iresp_data_ok, redirect_valid = 1'b0, out_valid, out_ready = 1'b1;
  logic [63:0] ireq_addr, redirect_pc = '0, out_pc;
  logic [31:0] iresp_data, out_instr;
  int          lat = 1;
  int          mcnt;
  int          checks = 0;
  int          errors = 0;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // Memory answers in the lat-th cycle of a request with the inverted address
  assign iresp_data_ok = ireq_valid && (mcnt == lat - 1);
  assign iresp_data    = ~ireq_addr[31:0];
  always @(posedge clk or negedge reset_n)
    if (!reset_n) mcnt <= 0;
    else if (iresp_data_ok || !ireq_valid) mcnt <= 0;
    else mcnt <= mcnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int l, input logic rdy);
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    lat = l;
    out_ready = rdy;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    step(1);
    do_reset(1, 1'b1);
    // streaming with a 1-cycle memory
    step(1);
    chk("s_v1", ireq_valid, 1);
    chk("s_a1", ireq_addr, 64'h8000_0000);
    step(1);
    chk("s_a2", ireq_addr, 64'h8000_0004);
    chk("s_ov2", out_valid, 1);
    chk("s_pc2", out_pc, 64'h8000_0000);
    step(1);
    chk("s_a3", ireq_addr, 64'h8000_0008);
    chk("s_pc3", out_pc, 64'h8000_0004);
    chk("s_in3", out_instr, 32'h7FFF_FFFB);
    // decode stall saturates the queue
    do_reset(1, 1'b0);
    step(5);
    chk("st_req_off", ireq_valid, 0);
    chk("st_ov", out_valid, 1);
    chk("st_pc_hold", out_pc, 64'h8000_0000);
    chk("st_in_hold", out_instr, 32'h7FFF_FFFF);
    out_ready = 1'b1;
    step(1);
    chk("st_pc1", out_pc, 64'h8000_0004);
    chk("st_rearm", ireq_addr, 64'h8000_0008);
    step(1);
    chk("st_pc2", out_pc, 64'h8000_0008);
    chk("st_in2", out_instr, 32'h7FFF_FFF7);
    // redirect while a 3-cycle request to _0008 is pending
    do_reset(3, 1'b1);
    step(7);
    chk("d_addr8", ireq_addr, 64'h8000_0008);
    chk("d_pc4", out_pc, 64'h8000_0004);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    step(1);
    redirect_valid = 1'b0;
    chk("d_hold_addr", ireq_addr, 64'h8000_0008);
    chk("d_hold_v", ireq_valid, 1);
    chk("d_flush", out_valid, 0);
    step(2);
    chk("d_new_addr", ireq_addr, 64'h8000_0100);
    chk("d_ov_a", out_valid, 0);
    step(2);
    chk("d_ov_b", out_valid, 0);
    step(1);
    chk("d_ov_c", out_valid, 1);
    chk("d_pc", out_pc, 64'h8000_0100);
    // redirect coincident with data_ok and a pop
    do_reset(1, 1'b0);
    step(3);
    out_ready = 1'b1;
    step(1);
    chk("c_ok", iresp_data_ok, 1);
    chk("c_ov", out_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    step(1);
    redirect_valid = 1'b0;
    chk("c_empty", out_valid, 0);
    chk("c_addr", ireq_addr, 64'h8000_0400);
    chk("c_req", ireq_valid, 1);
    step(1);
    chk("c_pc", out_pc, 64'h8000_0400);
    chk("c_in", out_instr, 32'h7FFF_FBFF);
    // two redirects during one drop
    do_reset(3, 1'b1);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    step(1);
    redirect_pc = 64'h8000_0300;
    step(1);
    redirect_valid = 1'b0;
    chk("r2_old_addr", ireq_addr, 64'h8000_0000);
    step(1);
    chk("r2_addr", ireq_addr, 64'h8000_0300);
    chk("r2_ov", out_valid, 0);
    step(2);
    chk("r2_ov2", out_valid, 0);
    step(1);
    chk("r2_pc", out_pc, 64'h8000_0300);
    // async reset mid-request with one queued entry
    do_reset(3, 1'b0);
    step(4);
    chk("ar_pre_ov", out_valid, 1);
    chk("ar_pre_req", ireq_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_req", ireq_valid, 0);
    chk("ar_ov", out_valid, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_in", out_instr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    chk("ar_addr", ireq_addr, 64'h8000_0000);
    chk("ar_req2", ireq_valid, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
